// File: rtl/asrm_uart_pkg.sv
// asrm_uart_pkg: register map, STATUS bit positions and FSM encodings shared by the UART
package asrm_uart_pkg;
  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_TXDATA = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_DIVISOR = 2'd3;
  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_PARITY_ERR = 6;
  localparam int ST_TX_OVERFLOW = 7;
  localparam logic [15:0] DIVISOR_MIN = 16'd4;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/asrm_uart_fifo_sync.sv
// asrm_sync_fifo: synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle
module asrm_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/asrm_uart_fifo.sv
// asrm_uart_fifo: FIFO-buffered UART with programmable bit divisor and sticky error flags.
// Defining ASRM_UART_PARITY_EN adds an even-parity bit to every frame.
module asrm_uart_fifo
  import asrm_uart_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF04,
  parameter int clk_freq = 1000000,
  parameter int default_baud = 9600,
  parameter int fifo_depth = 4
) (
  input logic clk,
  input logic reset,
  input logic enable,
  input logic [base_addr_size-1:0] addr,
  input logic write_en,
  input logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] data_out,
  input logic rx,
  output logic tx,
  output logic irq
);
  localparam logic [15:0] DIV_RESET = 16'(clk_freq / default_baud);
`ifdef ASRM_UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic [base_addr_size-1:0] off;
  logic [1:0] reg_sel;
  logic sel, wr;
  logic [15:0] div;
  logic [7:4] flags, err_set, err_clr;
  logic [7:0] status;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  tx_state_t t_state, t_next;
  rx_state_t r_state, r_next;
  logic [15:0] t_cnt, r_cnt;
  logic [2:0] t_idx, r_idx;
  logic [7:0] t_sh, r_sh;
  logic t_par, t_done, r_tick, r_bad, r1, r2, r3, stop_smp, par_fail;
  // wrapping subtraction turns the 4-address window test into one compare
  assign off = addr - base_addr;
  assign sel = enable && off < base_addr_size'(4);
  assign reg_sel = off[1:0];
  assign wr = sel && write_en;
  assign tx_push = wr && reg_sel == OFF_TXDATA;
  assign rx_pop = wr && reg_sel == OFF_RXDATA;
  assign irq = !rx_empty;
  always_ff @(posedge clk)
    if (reset) div <= DIV_RESET;
    else if (wr && reg_sel == OFF_DIVISOR) div <= data_in[15:0] < DIVISOR_MIN ? DIVISOR_MIN : data_in[15:0];
  always_comb begin
    err_set = '0;
    err_set[ST_RX_OVERRUN] = rx_push && rx_full && !rx_pop;
    err_set[ST_FRAME_ERR] = stop_smp && !r2;
    err_set[ST_PARITY_ERR] = par_fail;
    err_set[ST_TX_OVERFLOW] = tx_push && tx_full && !tx_pop;
  end
  assign err_clr = (wr && reg_sel == OFF_STATUS) ? data_in[7:4] : '0;
  always_ff @(posedge clk)
    flags <= reset ? '0 : (flags & ~err_clr) | err_set;
  always_comb begin
    status = {flags, 4'b0};
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL] = rx_full;
  end
  assign data_out = !sel ? '0
    : reg_sel == OFF_STATUS ? wordsize'(status)
    : reg_sel == OFF_RXDATA ? wordsize'(rx_empty ? 8'h00 : rx_head)
    : reg_sel == OFF_DIVISOR ? wordsize'(div) : '0;
  asrm_sync_fifo #(.W(8), .DEPTH(fifo_depth)) tx_fifo (
    .clk(clk), .rst(reset), .push(tx_push), .pop(tx_pop), .din(data_in[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );
  asrm_sync_fifo #(.W(8), .DEPTH(fifo_depth)) rx_fifo (
    .clk(clk), .rst(reset), .push(rx_push), .pop(rx_pop), .din(r_sh),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  assign t_done = t_cnt == 16'd1;
  always_comb begin
    t_next = t_state;
    tx_pop = 1'b0;
    case (t_state)
      TX_IDLE: begin
        tx_pop = !tx_empty;
        t_next = tx_empty ? TX_IDLE : TX_START;
      end
      TX_START: t_next = t_done ? TX_DATA : TX_START;
      TX_DATA: t_next = (t_done && t_idx == 3'd7) ? (PAR_EN ? TX_PARITY : TX_STOP) : TX_DATA;
      TX_PARITY: t_next = t_done ? TX_STOP : TX_PARITY;
      TX_STOP: begin
        tx_pop = t_done && !tx_empty;
        t_next = !t_done ? TX_STOP : tx_empty ? TX_IDLE : TX_START;
      end
      default: t_next = TX_IDLE;
    endcase
  end
  assign tx = t_state == TX_START ? 1'b0
    : t_state == TX_DATA ? t_sh[0]
    : t_state == TX_PARITY ? t_par : 1'b1;
  // the bit counter reloads from div only at bit boundaries, so a divisor write never stretches the current bit
  always_ff @(posedge clk)
    if (reset) begin
      t_state <= TX_IDLE;
      t_cnt <= '0;
      t_idx <= '0;
      t_sh <= '0;
      t_par <= 1'b0;
    end else begin
      t_state <= t_next;
      t_cnt <= (t_state == TX_IDLE || t_done) ? div : t_cnt - 16'd1;
      if (tx_pop) begin
        t_sh <= tx_head;
        t_par <= ^tx_head;
      end else if (t_state == TX_DATA && t_done) t_sh <= t_sh >> 1;
      if (t_state == TX_DATA && t_done) t_idx <= t_idx + 3'd1;
    end
  assign r_tick = r_cnt == 16'd1;
  assign stop_smp = r_state == RX_STOP && r_tick;
  assign par_fail = r_state == RX_PARITY && r_tick && (r2 != ^r_sh);
  assign rx_push = stop_smp && r2 && !r_bad;
  always_comb begin
    r_next = r_state;
    case (r_state)
      RX_IDLE: r_next = (r3 && !r2) ? RX_START : RX_IDLE;
      RX_START: r_next = !r_tick ? RX_START : r2 ? RX_IDLE : RX_DATA;
      RX_DATA: r_next = (r_tick && r_idx == 3'd7) ? (PAR_EN ? RX_PARITY : RX_STOP) : RX_DATA;
      RX_PARITY: r_next = r_tick ? RX_STOP : RX_PARITY;
      RX_STOP: r_next = r_tick ? RX_IDLE : RX_STOP;
      default: r_next = RX_IDLE;
    endcase
  end
  // half-divisor preload lands the start sample mid-bit; the synchroniser delay cancels out against the edge detect
  always_ff @(posedge clk)
    if (reset) begin
      {r3, r2, r1} <= 3'b111;
      r_state <= RX_IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_sh <= '0;
      r_bad <= 1'b0;
    end else begin
      {r3, r2, r1} <= {r2, r1, rx};
      r_state <= r_next;
      r_cnt <= (r_state == RX_IDLE) ? {1'b0, div[15:1]} : r_tick ? div : r_cnt - 16'd1;
      if (r_state == RX_DATA && r_tick) begin
        r_sh <= {r2, r_sh[7:1]};
        r_idx <= r_idx + 3'd1;
      end
      r_bad <= (r_state == RX_IDLE) ? 1'b0 : r_bad | par_fail;
    end
endmodule

// File: tb/tb_asrm_uart_fifo.sv
// tb_asrm_uart_fifo: directed scenario bench for asrm_uart_fifo
module tb_asrm_uart_fifo;
  localparam logic [15:0] BASE = 16'hFF04;
`ifdef ASRM_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, write_en = 1'b0, rx = 1'b1;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out;
  logic tx, irq;
  int total = 0, bad = 0;

  asrm_uart_fifo dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [1:0] off, input logic [15:0] d);
    enable = 1'b1; write_en = 1'b1; addr = BASE + 16'(off); data_in = d;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [15:0] d);
    enable = 1'b1; write_en = 1'b0; addr = BASE + 16'(off);
    #1 d = data_out;
    enable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < NB; i++) begin
      rx = (i == NB - 1) ? stop : fbit(b, i);
      repeat (8) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] v;
    int errs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL reset_status got=%h exp=0006", v); end
    bus_read(2'd3, v);
    total++; if (v !== 16'd104) begin bad++; $display("FAIL reset_divisor got=%0d exp=104", v); end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL reset_tx_idle low_samples=%0d exp=0", errs); end
  endtask

  task automatic test_divisor;
    logic [15:0] v;
    bus_write(2'd3, 16'd2);
    bus_read(2'd3, v);
    total++; if (v !== 16'd4) begin bad++; $display("FAIL divisor_clamp got=%0d exp=4", v); end
    bus_write(2'd3, 16'd8);
    bus_read(2'd3, v);
    total++; if (v !== 16'd8) begin bad++; $display("FAIL divisor_write got=%0d exp=8", v); end
  endtask

  task automatic test_tx_single;
    logic [15:0] v;
    int errs;
    bus_write(2'd1, 16'h00A5);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_pop_cycle got=%b exp=1", tx); end
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      errs = 0;
      for (int c = 0; c < 8; c++) begin
        if (tx !== fbit(8'hA5, b)) errs++;
        @(negedge clk);
      end
      total++; if (errs != 0) begin bad++; $display("FAIL tx_a5_bit%0d wrong_samples=%0d exp=0", b, errs); end
    end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_a5_idle got=%b exp=1", tx); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL tx_a5_status got=%h exp=0006", v); end
  endtask

  task automatic test_rx_single;
    logic [15:0] v;
    send_rx(8'h3C, 1'b1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_3c_irq got=%b exp=1", irq); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0002) begin bad++; $display("FAIL rx_3c_status got=%h exp=0002", v); end
    bus_read(2'd2, v);
    total++; if (v !== 16'h003C) begin bad++; $display("FAIL rx_3c_data got=%h exp=003c", v); end
    bus_write(2'd2, 16'h0000);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_pop_irq got=%b exp=0", irq); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL rx_pop_status got=%h exp=0006", v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [6];
    logic [15:0] v;
    int errs;
    q = '{8'h11, 8'h21, 8'h42, 8'h84, 8'h18, 8'h99};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          enable = 1'b1; write_en = 1'b1; addr = BASE + 16'd1; data_in = {8'h00, q[i]};
          @(negedge clk);
        end
        enable = 1'b0; write_en = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int f = 0; f < 5; f++)
          for (int b = 0; b < NB; b++) begin
            errs = 0;
            for (int c = 0; c < 8; c++) begin
              if (tx !== fbit(q[f], b)) errs++;
              @(negedge clk);
            end
            total++; if (errs != 0) begin bad++; $display("FAIL b2b_frame%0d_bit%0d wrong_samples=%0d exp=0", f, b, errs); end
          end
      end
    join
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", tx); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0086) begin bad++; $display("FAIL b2b_overflow_status got=%h exp=0086", v); end
    bus_write(2'd0, 16'h0080);
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL b2b_clear_status got=%h exp=0006", v); end
  endtask

  task automatic test_rx_overrun;
    logic [7:0] q [5];
    logic [15:0] v;
    q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    for (int i = 0; i < 5; i++) send_rx(q[i], 1'b1);
    bus_read(2'd0, v);
    total++; if (v !== 16'h001A) begin bad++; $display("FAIL overrun_status got=%h exp=001a", v); end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd2, v);
      total++; if (v !== {8'h00, q[i]}) begin bad++; $display("FAIL overrun_data%0d got=%h exp=%h", i, v, q[i]); end
      bus_write(2'd2, 16'h0000);
    end
    send_rx(8'h55, 1'b0);
    bus_read(2'd0, v);
    total++; if (v !== 16'h0032) begin bad++; $display("FAIL frame_err_status got=%h exp=0032", v); end
    bus_read(2'd2, v);
    total++; if (v !== 16'h0008) begin bad++; $display("FAIL frame_err_head got=%h exp=0008", v); end
    bus_write(2'd2, 16'h0000);
    bus_read(2'd0, v);
    total++; if (v !== 16'h0036) begin bad++; $display("FAIL drained_status got=%h exp=0036", v); end
    bus_write(2'd0, 16'h0030);
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL err_clear_status got=%h exp=0006", v); end
  endtask

  task automatic test_glitch;
    logic [15:0] v;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL glitch_status got=%h exp=0006", v); end
    send_rx(8'h5A, 1'b1);
    bus_read(2'd2, v);
    total++; if (v !== 16'h005A) begin bad++; $display("FAIL glitch_resync_data got=%h exp=005a", v); end
    bus_write(2'd2, 16'h0000);
  endtask

  task automatic test_reset_mid_tx;
    logic [15:0] v;
    int errs;
    bus_write(2'd1, 16'h0000);
    bus_write(2'd1, 16'h00FF);
    repeat (20) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midframe_tx got=%b exp=0", tx); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_mid_tx got=%b exp=1", tx); end
    bus_read(2'd0, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL reset_mid_status got=%h exp=0006", v); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd3, v);
    total++; if (v !== 16'd104) begin bad++; $display("FAIL reset_mid_divisor got=%0d exp=104", v); end
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL reset_mid_idle low_samples=%0d exp=0", errs); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_divisor();
    test_tx_single();
    test_rx_single();
    test_back_to_back();
    test_rx_overrun();
    test_glitch();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
